// File: rtl/median_mem_arb.sv
// rtl/median_mem_arb.sv - two-requester round-robin arbiter sharing one single-port memory
//
// Purpose: grants at most one of two requesters per cycle (round-robin on
// contention), registers the winning command onto the memory port, and
// routes returning read data back to the requester that issued it.
//
// Ports:
//   Clk, Rst                 clock (posedge), asynchronous active-low reset
//   Rk_EN/RW/Addr/WData      requester k command, held until Rk_Gnt
//   Rk_Gnt                   combinational grant for requester k
//   Rk_RData/Rk_RValid       read data return for requester k
//   Mem_EN/RW/Addr/WData     registered memory command
//   Mem_RData                memory read data, RD_LAT cycles after command
//   Busy                     command on the memory port or read in flight
module median_mem_arb #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8,
  parameter int RD_LAT  = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               R0_EN,
  input  logic               R0_RW,
  input  logic [A_WIDTH-1:0] R0_Addr,
  input  logic [D_WIDTH-1:0] R0_WData,
  output logic               R0_Gnt,
  output logic [D_WIDTH-1:0] R0_RData,
  output logic               R0_RValid,
  input  logic               R1_EN,
  input  logic               R1_RW,
  input  logic [A_WIDTH-1:0] R1_Addr,
  input  logic [D_WIDTH-1:0] R1_WData,
  output logic               R1_Gnt,
  output logic [D_WIDTH-1:0] R1_RData,
  output logic               R1_RValid,
  output logic               Mem_EN,
  output logic               Mem_RW,
  output logic [A_WIDTH-1:0] Mem_Addr,
  output logic [D_WIDTH-1:0] Mem_WData,
  input  logic [D_WIDTH-1:0] Mem_RData,
  output logic               Busy
);

  // ptr = 0 favours requester 0 on contention, 1 favours requester 1
  logic              ptr;
  logic              gnt0;
  logic              gnt1;
  // requester id travelling alongside the registered memory command
  logic              mem_id;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_id;

  always_comb begin
    gnt0 = R0_EN & (~R1_EN | ~ptr);
    gnt1 = R1_EN & ~gnt0;
  end

  assign R0_Gnt = gnt0;
  assign R1_Gnt = gnt1;

  // Command stage: the winner's fields appear on the memory port the cycle
  // after the grant; idle cycles drive an all-zero command.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr       <= 1'b0;
      Mem_EN    <= 1'b0;
      Mem_RW    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      mem_id    <= 1'b0;
    end else begin
      if (gnt0) begin
        ptr <= 1'b1;
      end else if (gnt1) begin
        ptr <= 1'b0;
      end
      Mem_EN <= gnt0 | gnt1;
      mem_id <= gnt1;
      if (gnt0) begin
        Mem_RW    <= R0_RW;
        Mem_Addr  <= R0_Addr;
        Mem_WData <= R0_WData;
      end else if (gnt1) begin
        Mem_RW    <= R1_RW;
        Mem_Addr  <= R1_Addr;
        Mem_WData <= R1_WData;
      end else begin
        Mem_RW    <= 1'b0;
        Mem_Addr  <= '0;
        Mem_WData <= '0;
      end
    end
  end

  // Read tags. The command register already supplies the grant-to-command
  // cycle, so the tag line only has to span command-to-data (RD_LAT
  // cycles); the last entry lines up with Mem_RData.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= Mem_EN & ~Mem_RW;
      tag_id[0]  <= mem_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign R0_RValid = tag_vld[RD_LAT-1] & ~tag_id[RD_LAT-1];
  assign R1_RValid = tag_vld[RD_LAT-1] &  tag_id[RD_LAT-1];
  assign R0_RData  = Mem_RData;
  assign R1_RData  = Mem_RData;
  assign Busy      = Mem_EN | (|tag_vld);

endmodule

// File: tb/tb_median_mem_arb.sv
// tb/tb_median_mem_arb.sv - self-checking bench for median_mem_arb
module tb_median_mem_arb;

  localparam int RD_LAT = 2;

  logic       Clk;
  logic       Rst;
  logic       R0_EN, R0_RW, R1_EN, R1_RW;
  logic [7:0] R0_Addr, R0_WData, R1_Addr, R1_WData;
  logic       R0_Gnt, R0_RValid, R1_Gnt, R1_RValid;
  logic [7:0] R0_RData, R1_RData;
  logic       Mem_EN, Mem_RW, Busy;
  logic [7:0] Mem_Addr, Mem_WData, Mem_RData;

  int errors = 0;
  int checks = 0;

  median_mem_arb #(.A_WIDTH(8), .D_WIDTH(8), .RD_LAT(RD_LAT)) dut (
    .Clk(Clk), .Rst(Rst),
    .R0_EN(R0_EN), .R0_RW(R0_RW), .R0_Addr(R0_Addr), .R0_WData(R0_WData),
    .R0_Gnt(R0_Gnt), .R0_RData(R0_RData), .R0_RValid(R0_RValid),
    .R1_EN(R1_EN), .R1_RW(R1_RW), .R1_Addr(R1_Addr), .R1_WData(R1_WData),
    .R1_Gnt(R1_Gnt), .R1_RData(R1_RData), .R1_RValid(R1_RValid),
    .Mem_EN(Mem_EN), .Mem_RW(Mem_RW), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData), .Busy(Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Memory harness: RD_LAT-cycle read pipeline, writes land on the command edge
  logic [7:0] mem [256];
  logic [7:0] rd_pipe [RD_LAT];
  bit         mem_ready;
  assign Mem_RData = rd_pipe[RD_LAT-1];

  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (Mem_EN && Mem_RW) begin
      mem[Mem_Addr] <= Mem_WData;
    end
    rd_pipe[0] <= mem[Mem_Addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model: grant rule, favoured requester, expected memory command,
  // and a list of outstanding reads keyed by the cycle their data returns.
  typedef struct {
    int         due;
    logic       id;
    logic [7:0] data;
  } rd_t;

  rd_t        pend[$];
  logic [7:0] shadow [256];
  bit         shadow_ready;
  logic       m_ptr;
  int         m_cyc;
  logic       m_en, m_rw;
  logic [7:0] m_addr, m_wdata;

  always @(posedge Clk or negedge Rst) begin
    logic g0, g1;
    if (!shadow_ready) begin
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
      shadow_ready = 1'b1;
    end
    if (!Rst) begin
      m_ptr = 1'b0; m_cyc = 0; pend.delete();
      m_en = 1'b0; m_rw = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
    end else begin
      g0 = R0_EN && (!R1_EN || m_ptr == 1'b0);
      g1 = R1_EN && !g0;
      while (pend.size() > 0 && pend[0].due <= m_cyc) void'(pend.pop_front());
      m_en    = g0 || g1;
      m_rw    = g0 ? R0_RW    : (g1 ? R1_RW    : 1'b0);
      m_addr  = g0 ? R0_Addr  : (g1 ? R1_Addr  : 8'h00);
      m_wdata = g0 ? R0_WData : (g1 ? R1_WData : 8'h00);
      if (m_en) begin
        if (m_rw) shadow[m_addr] = m_wdata;
        else pend.push_back('{due: m_cyc + 1 + RD_LAT, id: g1, data: shadow[m_addr]});
        m_ptr = g0 ? 1'b1 : 1'b0;
      end
      m_cyc = m_cyc + 1;
    end
  end

  task automatic idle_inputs;
    R0_EN = 0; R0_RW = 0; R0_Addr = 0; R0_WData = 0;
    R1_EN = 0; R1_RW = 0; R1_Addr = 0; R1_WData = 0;
  endtask

  // Leaves the bench at the start of cycle 0 after release.
  task automatic do_reset;
    idle_inputs();
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (Mem_EN !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", Mem_EN); end
    checks++; if (Mem_RW !== 1'b0) begin errors++; $display("FAIL reset_mem_rw got=%b exp=0", Mem_RW); end
    checks++; if (Mem_Addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h exp=00", Mem_Addr); end
    checks++; if (Mem_WData !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=00", Mem_WData); end
    checks++; if ({R0_RValid, R1_RValid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", R0_RValid, R1_RValid); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
  endtask

  task automatic test_single_read;
    logic e;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c == 0) begin R1_EN = 1; R1_RW = 1; R1_Addr = 8'h10; R1_WData = 8'hA7; end
      if (c == 5) begin R0_EN = 1; R0_RW = 0; R0_Addr = 8'h10; end
      @(negedge Clk);
      e = (c == 5);
      checks++; if (R0_Gnt !== e) begin errors++; $display("FAIL single_gnt0 c=%0d got=%b exp=%b", c, R0_Gnt, e); end
      e = (c == 0);
      checks++; if (R1_Gnt !== e) begin errors++; $display("FAIL single_gnt1 c=%0d got=%b exp=%b", c, R1_Gnt, e); end
      if (c == 6) begin
        checks++; if ({Mem_EN, Mem_RW, Mem_Addr} !== {1'b1, 1'b0, 8'h10}) begin errors++; $display("FAIL single_cmd got=%b%b%h exp=1010", Mem_EN, Mem_RW, Mem_Addr); end
      end
      e = (c == 5 + 1 + RD_LAT);
      checks++; if (R0_RValid !== e) begin errors++; $display("FAIL single_rv0 c=%0d got=%b exp=%b", c, R0_RValid, e); end
      checks++; if (R1_RValid !== 1'b0) begin errors++; $display("FAIL single_rv1 c=%0d got=%b exp=0", c, R1_RValid); end
      if (e) begin
        checks++; if (R0_RData !== 8'hA7) begin errors++; $display("FAIL single_rdata got=%h exp=a7", R0_RData); end
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_contention;
    logic e0, e1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      R0_EN = (c < 6); R0_Addr = 8'h00;
      R1_EN = (c < 6); R1_Addr = 8'h01;
      @(negedge Clk);
      e0 = (c < 6) && (c % 2 == 0);
      e1 = (c < 6) && (c % 2 == 1);
      checks++; if ({R0_Gnt, R1_Gnt} !== {e0, e1}) begin errors++; $display("FAIL cont_gnt c=%0d got=%b%b exp=%b%b", c, R0_Gnt, R1_Gnt, e0, e1); end
      e0 = (c >= 1 + RD_LAT) && (c < 7 + RD_LAT) && ((c - 1 - RD_LAT) % 2 == 0);
      e1 = (c >= 1 + RD_LAT) && (c < 7 + RD_LAT) && ((c - 1 - RD_LAT) % 2 == 1);
      checks++; if ({R0_RValid, R1_RValid} !== {e0, e1}) begin errors++; $display("FAIL cont_rv c=%0d got=%b%b exp=%b%b", c, R0_RValid, R1_RValid, e0, e1); end
      if (e0) begin
        checks++; if (R0_RData !== init_val(0)) begin errors++; $display("FAIL cont_rd0 c=%0d got=%h exp=%h", c, R0_RData, init_val(0)); end
      end
      if (e1) begin
        checks++; if (R1_RData !== init_val(1)) begin errors++; $display("FAIL cont_rd1 c=%0d got=%h exp=%h", c, R1_RData, init_val(1)); end
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_write_read;
    logic e;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      R1_EN = (c == 1); R1_RW = 1; R1_Addr = 8'h20; R1_WData = 8'h5C;
      R0_EN = (c == 2); R0_RW = 0; R0_Addr = 8'h20;
      @(negedge Clk);
      checks++; if ({R0_Gnt, R1_Gnt} !== {c == 2, c == 1}) begin errors++; $display("FAIL wr_gnt c=%0d got=%b%b", c, R0_Gnt, R1_Gnt); end
      e = (c == 2 + 1 + RD_LAT);
      checks++; if ({R0_RValid, R1_RValid} !== {e, 1'b0}) begin errors++; $display("FAIL wr_rv c=%0d got=%b%b exp=%b0", c, R0_RValid, R1_RValid, e); end
      if (e) begin
        checks++; if (R0_RData !== 8'h5C) begin errors++; $display("FAIL wr_rdata got=%h exp=5c", R0_RData); end
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_withdraw;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      R0_EN = (c != 1); R0_RW = 1; R0_Addr = 8'h40; R0_WData = 8'h11;
      R1_EN = (c != 1); R1_RW = 1; R1_Addr = 8'h41; R1_WData = 8'h22;
      @(negedge Clk);
      // c=0: R0 wins, R1 withdraws next cycle; c=2: R1 favoured; c=3: R0 favoured
      checks++; if ({R0_Gnt, R1_Gnt} !== {c == 0 || c == 3, c == 2}) begin errors++; $display("FAIL withdraw_gnt c=%0d got=%b%b", c, R0_Gnt, R1_Gnt); end
      @(posedge Clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      idle_inputs();
      R0_EN = (c == 0); R0_Addr = 8'h03;
      R1_EN = (c == 1); R1_Addr = 8'h04;
      @(posedge Clk); #1;
    end
    idle_inputs();
    @(negedge Clk);
    checks++; if ({Mem_EN, Busy} !== 2'b11) begin errors++; $display("FAIL midrst_pre got=%b%b exp=11", Mem_EN, Busy); end
    Rst = 1'b0;
    #1;
    checks++; if ({Mem_EN, Busy} !== 2'b00) begin errors++; $display("FAIL midrst_now got=%b%b exp=00", Mem_EN, Busy); end
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      checks++; if ({R0_RValid, R1_RValid} !== 2'b00) begin errors++; $display("FAIL midrst_hold_rv c=%0d got=%b%b", c, R0_RValid, R1_RValid); end
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      R0_EN = (c == 0); R0_RW = 1; R0_Addr = 8'h30; R0_WData = 8'h33;
      R1_EN = (c < 2);  R1_RW = 1; R1_Addr = 8'h31; R1_WData = 8'h44;
      @(negedge Clk);
      if (c == 0) begin
        checks++; if ({R0_Gnt, R1_Gnt} !== 2'b10) begin errors++; $display("FAIL midrst_first_gnt got=%b%b exp=10", R0_Gnt, R1_Gnt); end
      end
      checks++; if ({R0_RValid, R1_RValid} !== 2'b00) begin errors++; $display("FAIL midrst_rv c=%0d got=%b%b", c, R0_RValid, R1_RValid); end
      @(posedge Clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    logic e;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      idle_inputs();
      R0_EN = (c < 8); R0_Addr = 8'(c);
      @(negedge Clk);
      e = (c >= 1 + RD_LAT) && (c < 9 + RD_LAT);
      checks++; if (R0_RValid !== e) begin errors++; $display("FAIL b2b_rv c=%0d got=%b exp=%b", c, R0_RValid, e); end
      if (e) begin
        checks++; if (R0_RData !== init_val(c - 1 - RD_LAT)) begin errors++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, R0_RData, init_val(c - 1 - RD_LAT)); end
      end
      e = (c >= 1) && (c < 9 + RD_LAT);
      checks++; if (Busy !== e) begin errors++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, Busy, e); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_random;
    logic       seen0, seen1, e0, e1, eb;
    logic [7:0] ed;
    do_reset();
    seen0 = 0; seen1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!R0_EN || seen0) begin
        R0_EN = ($urandom_range(0, 2) != 0); R0_RW = 1'($urandom_range(0, 1));
        R0_Addr = 8'($urandom_range(0, 15)); R0_WData = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) R0_EN = 0;
      if (!R1_EN || seen1) begin
        R1_EN = ($urandom_range(0, 2) != 0); R1_RW = 1'($urandom_range(0, 1));
        R1_Addr = 8'($urandom_range(0, 15)); R1_WData = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) R1_EN = 0;
      @(negedge Clk);
      e0 = R0_EN && (!R1_EN || m_ptr == 1'b0);
      e1 = R1_EN && !e0;
      checks++; if ({R0_Gnt, R1_Gnt} !== {e0, e1}) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, R0_Gnt, R1_Gnt, e0, e1); end
      checks++; if ({Mem_EN, Mem_RW, Mem_Addr, Mem_WData} !== {m_en, m_rw, m_addr, m_wdata})
        begin errors++; $display("FAIL rnd_cmd c=%0d got=%b%b%h%h exp=%b%b%h%h", c, Mem_EN, Mem_RW, Mem_Addr, Mem_WData, m_en, m_rw, m_addr, m_wdata); end
      e0 = 0; e1 = 0; ed = 8'h00; eb = m_en;
      foreach (pend[i]) begin
        if (pend[i].due == m_cyc) begin
          e0 = !pend[i].id; e1 = pend[i].id; ed = pend[i].data;
        end
        if (pend[i].due - RD_LAT + 1 <= m_cyc && m_cyc <= pend[i].due) eb = 1;
      end
      checks++; if ({R0_RValid, R1_RValid} !== {e0, e1}) begin errors++; $display("FAIL rnd_rv c=%0d got=%b%b exp=%b%b", c, R0_RValid, R1_RValid, e0, e1); end
      checks++; if (Busy !== eb) begin errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, Busy, eb); end
      if (e0) begin
        checks++; if (R0_RData !== ed) begin errors++; $display("FAIL rnd_rd0 c=%0d got=%h exp=%h", c, R0_RData, ed); end
      end
      if (e1) begin
        checks++; if (R1_RData !== ed) begin errors++; $display("FAIL rnd_rd1 c=%0d got=%h exp=%h", c, R1_RData, ed); end
      end
      seen0 = R0_Gnt; seen1 = R1_Gnt;
      @(posedge Clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    Rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_withdraw();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
